// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package sub_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_t;

    localparam int SUB_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus of the serial subtractor.
// SERIAL_SUB_OVF_EN adds the signed-overflow flag ovf.
interface serial_subtractor_if
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEFAULT
);
    logic             start;
    logic [WIDTH-1:0] input1;
    logic [WIDTH-1:0] input2;
    logic             borrow_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (
        output start, input1, input2, borrow_in,
        input  busy, done, diff, borrow_out, ovf
    );

    modport slave (
        input  start, input1, input2, borrow_in,
        output busy, done, diff, borrow_out, ovf
    );
`else
    modport master (
        output start, input1, input2, borrow_in,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, input1, input2, borrow_in,
        output busy, done, diff, borrow_out
    );
`endif

endinterface

// File: rtl/serial_subtractor_fs.sv
// Single-bit full subtractor cell: d = a - b - bin, with borrow out.
module fs (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = input1 - input2 - borrow_in, one bit per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEFAULT
)(
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);

    localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    sub_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic             bor_q, bor_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_out_q, borrow_out_d;
    logic             done_q, done_d;
    logic             cell_d, cell_bout;

    fs u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (bor_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        bor_d        = bor_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.input1;
                    b_d     = bus.input2;
                    bor_d   = bus.borrow_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                bor_d = cell_bout;
                res_d = (WIDTH-1)'({cell_d, res_q} >> 1);
                cnt_d = cnt_q + 1'b1;
                // The top bit comes straight from the cell, so diff is loaded whole in one edge.
                if (cnt_q == LAST_BIT) begin
                    diff_d       = {cell_d, res_q};
                    borrow_out_d = cell_bout;
                    done_d       = 1'b1;
                    cnt_d        = '0;
                    state_d      = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the operand and partial-result registers are reset too, so no X ever reaches the cell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            bor_q        <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
            bor_q        <= bor_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
            done_q       <= done_d;
        end
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_out_q;

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits are shifted out of a_q/b_q, so keep copies for the overflow test.
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_q, ovf_d;

    always_comb begin
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
        if (state_q == IDLE && bus.start) begin
            a_msb_d = bus.input1[WIDTH-1];
            b_msb_d = bus.input2[WIDTH-1];
        end
        if (state_q == SHIFT && cnt_q == LAST_BIT) begin
            ovf_d = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`endif

endmodule
